// File: rtl/seg_scan_serial_ctrl.sv
// seg_scan_serial_ctrl: multiplexed 7-segment scan controller.
// Each digit slot does four things in order:
//   1. loads a 16-bit {digit-select, segments} word into the downstream serializer;
//   2. shifts the word out LSB first on ser_clk;
//   3. pulses latch for the external 74HC595-style chain;
//   4. dwells for DWELL_CYCLES, then moves on to the next digit.
// Optional build macro: SEG_ACTIVE_LOW_EN inverts the whole load word for
// common-anode displays; with it, blank gives a segment byte of 8'hFF.
module seg_scan_serial_ctrl #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DWELL_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*NUM_DIGITS-1:0]   seg_data,
    input  logic                      blank,
    output logic                      sr_ena,
    output logic                      sr_write,
    output logic [15:0]               sr_data,
    output logic                      ser_clk,
    output logic                      latch,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]         DIGIT_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]         BIT_LAST   = 4'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        LATCH = 3'd4,
        DWELL = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_nxt;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_nxt;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_nxt;
    logic [2:0]           digit_idx;
    logic [2:0]           digit_nxt;

    logic                 div_last;
    logic                 dwell_last;
    logic                 digit_last;
    logic [7:0]           sel_byte;
    logic [7:0]           seg_byte;
    logic [15:0]          load_word;

    assign div_last   = (div_cnt == DIV_LAST);
    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign digit_last = (digit_idx == DIGIT_LAST);

    // State and slot counters; a reset drops whatever slot was in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            dwell_cnt <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            dwell_cnt <= dwell_nxt;
            digit_idx <= digit_nxt;
        end
    end

    // Next state plus counter updates for the slot sequence
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        dwell_nxt = dwell_cnt;
        digit_nxt = digit_idx;
        case (state)
            IDLE: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                div_nxt   = '0;
                bit_nxt   = '0;
                state_nxt = LOW;
            end
            LOW: begin
                if (div_last) begin
                    div_nxt   = '0;
                    state_nxt = HIGH;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_nxt   = '0;
                    bit_nxt   = bit_cnt + 4'd1;
                    state_nxt = (bit_cnt == BIT_LAST) ? LATCH : LOW;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_nxt   = '0;
                    dwell_nxt = '0;
                    state_nxt = DWELL;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            DWELL: begin
                if (dwell_last) begin
                    dwell_nxt = '0;
                    digit_nxt = digit_last ? 3'd0 : (digit_idx + 3'd1);
                    state_nxt = LOAD;
                end else begin
                    dwell_nxt = dwell_cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Build the load word for the current digit; seg_data/blank only matter in LOAD
    always_comb begin
        seg_byte = 8'h00;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == 3'(i)) begin
                seg_byte = seg_data[8*i +: 8];
            end
        end
        if (blank) begin
            seg_byte = 8'h00;
        end
        sel_byte = 8'h01 << digit_idx;
`ifdef SEG_ACTIVE_LOW_EN
        load_word = ~{sel_byte, seg_byte};
`else
        load_word = {sel_byte, seg_byte};
`endif
    end

    // Moore output decode; all outputs are held low while rst is asserted
    always_comb begin
        sr_ena     = 1'b0;
        sr_write   = 1'b0;
        sr_data    = 16'h0000;
        ser_clk    = 1'b0;
        latch      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                LOAD: begin
                    sr_ena   = 1'b1;
                    sr_write = 1'b1;
                    sr_data  = load_word;
                end
                HIGH: begin
                    ser_clk = 1'b1;
                    sr_ena  = div_last;
                end
                LATCH: begin
                    latch = 1'b1;
                end
                DWELL: begin
                    frame_done = dwell_last && digit_last;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_serial_ctrl.sv
// Testbench for seg_scan_serial_ctrl. Honours SEG_ACTIVE_LOW_EN for expected load words.
// dut0 uses the default parameters and dut1 uses the minimal-timing configuration.
module tb_seg_scan_serial_ctrl;

    localparam int unsigned ND = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [8*ND-1:0]   seg_data;
    logic              blank;
    logic              sr_ena, sr_write, ser_clk, latch, busy, frame_done;
    logic [15:0]       sr_data;

    logic [7:0]        seg_data1;
    logic              blank1;
    logic              sr_ena1, sr_write1, ser_clk1, latch1, busy1, frame_done1;
    logic [15:0]       sr_data1;

    seg_scan_serial_ctrl #(.NUM_DIGITS(6), .CLK_DIV(2), .DWELL_CYCLES(10)) dut0 (
        .clk(clk), .rst(rst), .seg_data(seg_data), .blank(blank),
        .sr_ena(sr_ena), .sr_write(sr_write), .sr_data(sr_data), .ser_clk(ser_clk),
        .latch(latch), .busy(busy), .frame_done(frame_done)
    );

    seg_scan_serial_ctrl #(.NUM_DIGITS(1), .CLK_DIV(1), .DWELL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_data(seg_data1), .blank(blank1),
        .sr_ena(sr_ena1), .sr_write(sr_write1), .sr_data(sr_data1), .ser_clk(ser_clk1),
        .latch(latch1), .busy(busy1), .frame_done(frame_done1)
    );

    logic [21:0] outs0, outs1;
    assign outs0 = {sr_ena, sr_write, sr_data, ser_clk, latch, busy, frame_done};
    assign outs1 = {sr_ena1, sr_write1, sr_data1, ser_clk1, latch1, busy1, frame_done1};

    typedef struct {
        int          digit;
        logic [7:0]  seg;
        logic        blank;
        logic [15:0] word;
    } vec_t;
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rise_cnt = 0;
    int load_cyc = 0;
    int latch_start = 0;
    int latch_run = 0;
    int last_latch_len = 0;
    int latch_total = 0;
    int fd_cnt = 0;
    int prev_fd_cyc = 0;
    int last_fd_cyc = 0;
    int l1_prev = -1;
    int l1_first = -1;
    int p1_min = 1000000;
    int p1_max = 0;
    int fd1_bad = 0;
    int fd1_cnt = 0;
    logic [15:0] sr_model = 16'h0000;
    logic [15:0] rx = 16'h0000;
    logic [15:0] w1_last = 16'h0000;
    logic prev_ser_clk = 1'b0;
    logic prev_latch = 1'b0;
    logic prev_fd1 = 1'b0;

    int l0;
    int prev_load;
    int snap;

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef SEG_ACTIVE_LOW_EN
        return ~w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and update the serializer/chain model and trackers.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ser_clk && !prev_ser_clk) begin
            if (rise_cnt < 16) rx[rise_cnt] = sr_model[0];
            rise_cnt++;
        end
        if (sr_ena && sr_write) begin
            sr_model = sr_data;
            rise_cnt = 0;
            load_cyc = cyc;
        end else if (sr_ena) begin
            sr_model = {1'b0, sr_model[15:1]};
        end
        prev_ser_clk = ser_clk;
        if (latch) begin
            if (!prev_latch) begin
                latch_start = cyc;
                latch_total++;
                latch_run = 0;
            end
            latch_run++;
        end else if (prev_latch) begin
            last_latch_len = latch_run;
        end
        prev_latch = latch;
        if (frame_done) begin
            fd_cnt++;
            prev_fd_cyc = last_fd_cyc;
            last_fd_cyc = cyc;
        end
        if (sr_write1) begin
            w1_last = sr_data1;
            if (l1_prev >= 0) begin
                if (cyc - l1_prev < p1_min) p1_min = cyc - l1_prev;
                if (cyc - l1_prev > p1_max) p1_max = cyc - l1_prev;
                if (!prev_fd1) fd1_bad++;
            end else begin
                l1_first = cyc;
            end
            l1_prev = cyc;
        end
        if (frame_done1) fd1_cnt++;
        prev_fd1 = frame_done1;
    endtask

    task automatic wait_load(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!sr_write && n < bound);
        check("load_seen", 32'(sr_write), 32'd1);
    endtask

    initial begin
        vecs[0] = '{digit: 1, seg: 8'h06, blank: 1'b0, word: 16'h0206};
        vecs[1] = '{digit: 2, seg: 8'h5B, blank: 1'b0, word: 16'h045B};
        vecs[2] = '{digit: 3, seg: 8'h4F, blank: 1'b0, word: 16'h084F};
        vecs[3] = '{digit: 4, seg: 8'h66, blank: 1'b0, word: 16'h1066};
        vecs[4] = '{digit: 5, seg: 8'h6D, blank: 1'b0, word: 16'h206D};
        vecs[5] = '{digit: 0, seg: 8'h7D, blank: 1'b0, word: 16'h017D};
        vecs[6] = '{digit: 1, seg: 8'h07, blank: 1'b0, word: 16'h0207};
        vecs[7] = '{digit: 2, seg: 8'h7F, blank: 1'b0, word: 16'h047F};
        vecs[8] = '{digit: 3, seg: 8'hFF, blank: 1'b1, word: 16'h0800};
        vecs[9] = '{digit: 4, seg: 8'h6F, blank: 1'b0, word: 16'h106F};

        rst       = 1'b1;
        blank     = 1'b0;
        blank1    = 1'b0;
        seg_data  = '0;
        seg_data[7:0] = 8'h3F;
        seg_data1 = 8'hA5;

        // Reset held for 3 cycles: everything low on both instances
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs0", 32'(outs0), 32'd0);
            check("reset_outs1", 32'(outs1), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("idle_after_release", 32'({busy, sr_write}), 32'd0);
        tick();
        check("first_load", 32'({sr_write, sr_data}), 32'({1'b1, exp_word(16'h013F)}));
        l0 = cyc;

        // Digit 0 shift-out of 8'h3F, then a 2-cycle latch
        while (cyc < l0 + 70) tick();
        check("ser_rises", 32'(rise_cnt), 32'd16);
        check("ser_bits", 32'(rx), 32'(exp_word(16'h013F)));
        check("latch_len", 32'(last_latch_len), 32'd2);
        check("latch_start", 32'(latch_start - l0), 32'd65);

        // Table of load words across digits and the blank case
        for (int i = 0; i < 10; i++) begin
            tick();
            seg_data[8*vecs[i].digit +: 8] = vecs[i].seg;
            blank = vecs[i].blank;
            prev_load = load_cyc;
            wait_load(200);
            check($sformatf("vec%0d_word", i), 32'(sr_data), 32'(exp_word(vecs[i].word)));
            check($sformatf("vec%0d_period", i), 32'(cyc - prev_load), 32'd77);
        end

        // Frame pulse timing and wrap back to digit 0
        for (int n = 0; n < 600 && fd_cnt < 2; n++) tick();
        check("fd_count", 32'(fd_cnt), 32'd2);
        check("fd_first", 32'(prev_fd_cyc - l0), 32'd461);
        check("fd_period", 32'(last_fd_cyc - prev_fd_cyc), 32'd462);
        tick();
        check("fd_width", 32'(frame_done), 32'd0);
        check("wrap_load", 32'({sr_write, sr_data}), 32'({1'b1, exp_word(16'h017D)}));

        // Minimal-timing instance: 35-cycle slots, frame_done every slot
        check("p1_first_load", 32'(l1_first - l0), 32'd0);
        check("p1_min", 32'(p1_min), 32'd35);
        check("p1_max", 32'(p1_max), 32'd35);
        check("p1_fd_missing", 32'(fd1_bad), 32'd0);
        check("p1_fd_seen", 32'(fd1_cnt >= 20), 32'd1);
        check("p1_word", 32'(w1_last), 32'(exp_word(16'h01A5)));

        // Reset during the HIGH phase of bit 7 of digit 2
        wait_load(200);
        wait_load(200);
        check("t5_digit2", 32'(sr_data), 32'(exp_word(16'h047F)));
        for (int n = 0; n < 100 && rise_cnt < 8; n++) tick();
        check("t5_bit7_rise", 32'(rise_cnt), 32'd8);
        check("t5_bit7_high", 32'(ser_clk), 32'd1);
        snap = latch_total;
        rst = 1'b1;
        tick();
        check("t5_rst_outs_a", 32'(outs0), 32'd0);
        tick();
        check("t5_rst_outs_b", 32'(outs0), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_idle", 32'({busy, sr_write}), 32'd0);
        tick();
        check("t5_load_digit0", 32'({sr_write, sr_data}), 32'({1'b1, exp_word(16'h017D)}));
        check("t5_no_latch", 32'(latch_total - snap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
